fft_stage_ctrl: RTL and testbench

- Sequencer for one radix-2 single-delay-feedback (SDF) DIF stage of the CORDIC-based fixed-point FFT. Default configuration is the 16-point stage that uses the 8-entry twiddle-angle ROM.
- Counts accepted input samples and selects pass or butterfly mode for the delay line.
- Issues twiddle-angle ROM addresses and sends CORDIC rotate enables, delayed so they line up with the registered ROM output.
- At end of stream, drains the delay line with internally generated strobes.

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_ctrl_delay.sv | 28 ++
 rtl/fft_stage_ctrl.sv | 137 +++++++++++++
 tb/tb_fft_stage_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared state, control-bundle types and default sizes for the SDF FFT stage.
package fft_pkg;
    localparam int N_PTS_DEF   = 16;
    localparam int ROM_LAT_DEF = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic dl_shift;
        logic bf_sel;
        logic rot_en;
        logic out_valid;
        logic out_sof;
    } ctl_t;
endpackage

// File: rtl/fft_ctrl_delay.sv
// fft_ctrl_delay: LAT-deep register pipe for the datapath control bundle, reset to zero.
module fft_ctrl_delay
    import fft_pkg::*;
#(
    parameter int LAT = ROM_LAT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  ctl_t i_ctl,
    output ctl_t o_ctl
);
    generate
        if (LAT == 0) begin : g_pass
            assign o_ctl = i_ctl;
        end else begin : g_pipe
            ctl_t [LAT-1:0] r_pipe;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe[0] <= i_ctl;
                    for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign o_ctl = r_pipe[LAT-1];
        end
    endgenerate
endmodule

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: sequencer for one radix-2 SDF DIF stage; counts samples, issues twiddle
// addresses and delay-line/CORDIC strobes aligned to the ROM latency, and drains at end of stream.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int N_PTS   = N_PTS_DEF,
    parameter int ADDR_W  = $clog2(N_PTS / 2),
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic              i_last,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_dl_shift,
    output logic              o_bf_sel,
    output logic              o_rot_en,
    output logic              o_out_valid,
    output logic              o_out_sof,
    output logic              o_busy,
    output logic              o_sync_err
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LP_D    = CNT_W'(N_PTS / 2);
    localparam logic [CNT_W-1:0] LP_DM1  = CNT_W'(N_PTS / 2 - 1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(N_PTS - 1);

    state_t            r_state, w_state_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx, w_k;
    logic              r_pending, w_pend_nx;
    logic              w_acc, w_evt, w_p, w_err, w_half;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_sync_err;
    ctl_t              r_ctl, w_ctl, w_ctl_dly;

    assign o_ready = (r_state != DRAIN);
    assign o_busy  = (r_state != IDLE);
    assign w_acc   = i_valid & o_ready;
    assign w_half  = w_k[CNT_W-1];

    // w_evt marks a sample slot (accept or drain strobe) with index w_k and pending flag w_p
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_pend_nx  = r_pending;
        w_evt      = 1'b0;
        w_k        = r_cnt;
        w_p        = r_pending;
        w_err      = 1'b0;
        case (r_state)
            IDLE: if (w_acc) begin
                if (i_sof) begin
                    w_evt      = 1'b1;
                    w_k        = '0;
                    w_cnt_nx   = CNT_W'(1);
                    w_state_nx = RUN;
                end else begin
                    w_err = 1'b1;
                end
            end
            RUN: if (w_acc) begin
                if (i_sof && r_cnt != '0) begin
                    w_err     = 1'b1;
                    w_pend_nx = 1'b0;
                    w_evt     = 1'b1;
                    w_k       = '0;
                    w_p       = 1'b0;
                    w_cnt_nx  = CNT_W'(1);
                end else if (!i_sof && r_cnt == '0) begin
                    w_err = 1'b1;
                end else begin
                    w_evt    = 1'b1;
                    w_cnt_nx = r_cnt + CNT_W'(1);
                    if (r_cnt == LP_LAST) begin
                        w_pend_nx = 1'b1;
                        if (i_last) w_state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                w_evt    = 1'b1;
                w_p      = 1'b1;
                w_cnt_nx = r_cnt + CNT_W'(1);
                if (r_cnt == LP_DM1) begin
                    w_pend_nx  = 1'b0;
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_ctl           = '0;
        w_ctl.dl_shift  = w_evt;
        w_ctl.bf_sel    = w_evt & w_half;
        w_ctl.rot_en    = w_evt & ~w_half & w_p;
        w_ctl.out_valid = w_evt & (w_half | w_p);
        w_ctl.out_sof   = w_evt & (w_k == LP_D);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_pending  <= 1'b0;
            r_rom_addr <= '0;
            r_sync_err <= 1'b0;
            r_ctl      <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_pending  <= w_pend_nx;
            r_sync_err <= w_err;
            r_ctl      <= w_ctl;
            if (w_evt) r_rom_addr <= w_half ? '0 : w_k[ADDR_W-1:0];
        end
    end

    fft_ctrl_delay #(.LAT(ROM_LAT)) u_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ctl   (r_ctl),
        .o_ctl   (w_ctl_dly)
    );

    assign o_rom_addr  = r_rom_addr;
    assign o_sync_err  = r_sync_err;
    assign o_dl_shift  = w_ctl_dly.dl_shift;
    assign o_bf_sel    = w_ctl_dly.bf_sel;
    assign o_rot_en    = w_ctl_dly.rot_en;
    assign o_out_valid = w_ctl_dly.out_valid;
    assign o_out_sof   = w_ctl_dly.out_sof;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb_fft_stage_ctrl: directed and random framing scenarios on ROM_LAT=1 and ROM_LAT=2 instances,
// checked against a per-sample schedule model with latency queues.
module tb_fft_stage_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, sof = 1'b0, last = 1'b0;
    always #5 clk = ~clk;

    logic       rdy1, dl1, bf1, rot1, ov1, os1, busy1, err1;
    logic       rdy2, dl2, bf2, rot2, ov2, os2, busy2, err2;
    logic [2:0] addr1, addr2;

    fft_stage_ctrl #(.N_PTS(16), .ADDR_W(3), .ROM_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_sof(sof), .i_last(last),
        .o_ready(rdy1), .o_rom_addr(addr1), .o_dl_shift(dl1), .o_bf_sel(bf1), .o_rot_en(rot1),
        .o_out_valid(ov1), .o_out_sof(os1), .o_busy(busy1), .o_sync_err(err1));

    fft_stage_ctrl #(.N_PTS(16), .ADDR_W(3), .ROM_LAT(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_sof(sof), .i_last(last),
        .o_ready(rdy2), .o_rom_addr(addr2), .o_dl_shift(dl2), .o_bf_sel(bf2), .o_rot_en(rot2),
        .o_out_valid(ov2), .o_out_sof(os2), .o_busy(busy2), .o_sync_err(err2));

    int checks = 0, failures = 0;

    // model: frame position, drain progress, pending flag, expected outputs
    bit         m_framed, m_drain, m_pend;
    int         m_idx, m_dcnt;
    logic [2:0] e_addr;
    logic       e_err, e_ready, e_busy;
    logic [4:0] e_c1, e_c2;
    logic [4:0] q1[$], q2[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_framed = 0; m_drain = 0; m_pend = 0; m_idx = 0; m_dcnt = 0;
        e_addr = '0; e_err = 0; e_ready = 1; e_busy = 0; e_c1 = '0; e_c2 = '0;
        q1 = {}; q2 = {};
        q1.push_back(5'd0);
        q2.push_back(5'd0); q2.push_back(5'd0);
    endtask

    task automatic model_step(input bit v, input bit s, input bit l);
        bit has = 0;
        int k = 0;
        bit p = 0;
        logic [4:0] ev = '0;
        e_err = 0;
        if (m_drain) begin
            has = 1; k = m_dcnt; p = 1; m_dcnt++;
            if (m_dcnt == 8) begin m_drain = 0; m_pend = 0; m_framed = 0; m_idx = 0; end
        end else if (v) begin
            if (!m_framed) begin
                if (s) begin m_framed = 1; has = 1; k = 0; p = m_pend; m_idx = 1; end
                else e_err = 1;
            end else if (s && m_idx != 0) begin
                e_err = 1; m_pend = 0; has = 1; k = 0; p = 0; m_idx = 1;
            end else if (!s && m_idx == 0) begin
                e_err = 1;
            end else begin
                has = 1; k = m_idx; p = m_pend;
                if (m_idx == 15) begin
                    m_pend = 1;
                    if (l) begin m_drain = 1; m_dcnt = 0; end
                end
                m_idx = (m_idx + 1) % 16;
            end
        end
        if (has) begin
            ev = {1'b1, k >= 8, (k < 8) && p, (k >= 8) || p, k == 8};
            e_addr = (k < 8) ? 3'(k) : 3'd0;
        end
        q1.push_back(ev); e_c1 = q1.pop_front();
        q2.push_back(ev); e_c2 = q2.pop_front();
        e_ready = !m_drain;
        e_busy  = m_framed || m_drain;
    endtask

    task automatic check_all();
        chk("ready1", 8'(rdy1), 8'(e_ready));
        chk("busy1", 8'(busy1), 8'(e_busy));
        chk("addr1", 8'(addr1), 8'(e_addr));
        chk("err1", 8'(err1), 8'(e_err));
        chk("ctl1", 8'({dl1, bf1, rot1, ov1, os1}), 8'(e_c1));
        chk("ready2", 8'(rdy2), 8'(e_ready));
        chk("busy2", 8'(busy2), 8'(e_busy));
        chk("addr2", 8'(addr2), 8'(e_addr));
        chk("err2", 8'(err2), 8'(e_err));
        chk("ctl2", 8'({dl2, bf2, rot2, ov2, os2}), 8'(e_c2));
    endtask

    task automatic cyc(input bit v, input bit s, input bit l);
        @(negedge clk);
        valid = v; sof = s; last = l;
        model_step(v, s, l);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic frame(input int n, input bit l, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) cyc(0, 0, 0);
            cyc(1, i == 0, l && i == n - 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc($urandom_range(0, 1), $urandom_range(0, 1), 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        frame(16, 1, 0);          // single frame then drain
        idle(12);

        frame(16, 0, 0);          // back-to-back frames
        frame(16, 1, 0);
        idle(12);

        frame(16, 1, 1);          // stretched by valid gaps
        idle(12);

        frame(5, 0, 0);           // sof at index 5 restarts the frame
        cyc(1, 1, 0);
        for (int i = 1; i < 16; i++) cyc(1, 0, 0);
        frame(16, 1, 0);
        idle(12);

        cyc(1, 0, 0);             // no sof in idle
        cyc(1, 0, 0);
        frame(16, 0, 0);
        cyc(1, 0, 0);             // no sof at index 0 while running
        frame(16, 1, 0);

        frame(16, 1, 0);          // reset during drain strobe 3
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc(0, 0, 0);

        for (int c = 0; c < 600; c++) begin
            bit v, s, l;
            v = $urandom_range(0, 3) != 0;
            s = m_framed ? (m_idx == 0) : 1'b1;
            if ($urandom_range(0, 19) == 0) s = ~s;
            l = (m_idx == 15) && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) l = 1'b1;
            cyc(v, s, l);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
